// File: rtl/twos_comp_deser.sv
// Serial-to-parallel receiver with on-the-fly two's-complement negation.
// LSB-first bits in, WIDTH-bit words out over valid/ready, plus overflow and framing-error flags.
module twos_comp_deser #(
   parameter int WIDTH  = 4,
   parameter bit NEGATE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   input  logic             s_first,
   input  logic             s_bit,
   output logic             s_ready,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_ovf,
   output logic             err
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             seen_one;
   logic [WIDTH-1:0] sr;
   logic             hold_ovf;

   logic             eff_seen;
   logic             out_bit;
   logic [WIDTH-1:0] new_sr;
   logic             new_ovf;
   logic             out_free;

   // A first-flagged bit always starts a fresh frame, so its history is ignored.
   assign eff_seen = s_first ? 1'b0 : seen_one;
   assign out_bit  = NEGATE ? (s_bit ^ eff_seen) : s_bit;
   assign new_sr   = {out_bit, sr[WIDTH-1:1]};
   assign new_ovf  = NEGATE && s_bit && !eff_seen;
   assign out_free = !m_valid || m_ready;
   assign s_ready  = (state != HOLD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         seen_one <= 1'b0;
         sr       <= '0;
         hold_ovf <= 1'b0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         m_ovf    <= 1'b0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         if (m_valid && m_ready)
            m_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (s_valid) begin
                  if (s_first) begin
                     sr       <= new_sr;
                     cnt      <= CW'(1);
                     seen_one <= s_bit;
                     state    <= SHIFT;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               if (s_valid) begin
                  if (s_first) begin
                     // Restart: drop the partial frame and treat this bit as bit 0.
                     sr       <= new_sr;
                     cnt      <= CW'(1);
                     seen_one <= s_bit;
                     err      <= 1'b1;
                  end else if (cnt == CW'(WIDTH - 1)) begin
                     cnt      <= '0;
                     seen_one <= 1'b0;
                     if (out_free) begin
                        m_data  <= new_sr;
                        m_ovf   <= new_ovf;
                        m_valid <= 1'b1;
                        state   <= IDLE;
                     end else begin
                        sr       <= new_sr;
                        hold_ovf <= new_ovf;
                        state    <= HOLD;
                     end
                  end else begin
                     sr       <= new_sr;
                     cnt      <= cnt + CW'(1);
                     seen_one <= seen_one | s_bit;
                  end
               end
            end
            HOLD: begin
               if (out_free) begin
                  m_data  <= sr;
                  m_ovf   <= hold_ovf;
                  m_valid <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_twos_comp_deser.sv
// Scoreboard bench: a negating and a plain instance share one serial stream;
// expected words are queued at frame completion and popped by a monitor at each handshake.
module tb_twos_comp_deser;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         s_valid, s_first, s_bit, m_ready;
   logic         s_ready, m_valid, m_ovf, err;
   logic [W-1:0] m_data;
   logic         s_ready_r, m_valid_r, m_ovf_r, err_r;
   logic [W-1:0] m_data_r;

   int n_chk  = 0;
   int n_fail = 0;
   int err_cnt = 0;
   int mv_cnt  = 0;

   logic [W:0] q_neg[$];
   logic [W:0] q_raw[$];

   logic         prev_v, prev_r;
   logic [W-1:0] prev_d;

   always #5 clk = ~clk;

   twos_comp_deser #(.WIDTH(W), .NEGATE(1'b1)) dut (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_first(s_first), .s_bit(s_bit),
      .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
      .m_ovf(m_ovf), .err(err)
   );

   twos_comp_deser #(.WIDTH(W), .NEGATE(1'b0)) dut_raw (
      .clk(clk), .reset(reset), .s_valid(s_valid), .s_first(s_first), .s_bit(s_bit),
      .s_ready(s_ready_r), .m_valid(m_valid_r), .m_ready(m_ready), .m_data(m_data_r),
      .m_ovf(m_ovf_r), .err(err_r)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops at every handshake, also tracks err pulses and output stability.
   always @(negedge clk) begin
      if (reset) begin
         prev_v = 1'b0;
      end else begin
         if (err) err_cnt++;
         if (m_valid) mv_cnt++;
         if (prev_v && !prev_r && m_valid)
            chk("hold_stable", int'(m_data), int'(prev_d));
         if (m_valid && m_ready) begin
            if (q_neg.size() == 0) chk("neg_unexpected_word", 1, 0);
            else begin
               logic [W:0] e;
               e = q_neg.pop_front();
               chk("neg_data", int'(m_data), int'(e[W-1:0]));
               chk("neg_ovf", int'(m_ovf), int'(e[W]));
            end
         end
         if (m_valid_r && m_ready) begin
            if (q_raw.size() == 0) chk("raw_unexpected_word", 1, 0);
            else begin
               logic [W:0] e;
               e = q_raw.pop_front();
               chk("raw_data", int'(m_data_r), int'(e[W-1:0]));
               chk("raw_ovf", int'(m_ovf_r), int'(e[W]));
            end
         end
         prev_v = m_valid;
         prev_r = m_ready;
         prev_d = m_data;
      end
   end

   // Present one bit; waits (bounded) while the receiver is stalled.
   task automatic send_bit(input logic b, input logic f);
      int n;
      s_valid = 1'b1; s_first = f; s_bit = b;
      n = 0;
      while (!s_ready && n < 200) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 200) chk("s_ready_timeout", 0, 1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_first = 1'b0;
   endtask

   task automatic send_frame(input logic [W-1:0] raw, input logic [W-1:0] exp_neg,
                             input logic exp_ovf);
      for (int i = 0; i < W; i++) send_bit(raw[i], i == 0);
      q_neg.push_back({exp_ovf, exp_neg});
      q_raw.push_back({1'b0, raw});
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   initial begin
      int e0, m0;
      reset = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_bit = 1'b0; m_ready = 1'b1;
      idle(2);
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_s_ready", int'(s_ready), 1);
      chk("rst_err", int'(err), 0);
      reset = 1'b0;
      idle(1);

      // Basic frame: latency one cycle, valid for exactly one cycle.
      m0 = mv_cnt;
      send_frame(4'b0101, 4'b1011, 1'b0);
      chk("latency_m_valid", int'(m_valid), 1);
      chk("latency_m_data", int'(m_data), 4'hB);
      idle(4);
      chk("m_valid_one_cycle", mv_cnt - m0, 1);

      // Zero and most-negative back-to-back.
      send_frame(4'b0000, 4'b0000, 1'b0);
      send_frame(4'b1000, 4'b1000, 1'b1);
      idle(3);
      chk("b2b_drained", q_neg.size(), 0);

      // Back-pressure: first word held, second parks in HOLD.
      m_ready = 1'b0;
      send_frame(4'b0001, 4'b1111, 1'b0);
      send_frame(4'b0011, 4'b1101, 1'b0);
      idle(2);
      chk("hold_s_ready", int'(s_ready), 0);
      chk("hold_m_data", int'(m_data), 4'hF);
      chk("hold_m_valid", int'(m_valid), 1);
      m_ready = 1'b1;
      idle(4);
      chk("hold_released_s_ready", int'(s_ready), 1);
      chk("hold_drained", q_neg.size(), 0);

      // Mid-frame restart.
      e0 = err_cnt;
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      send_frame(4'b0011, 4'b1101, 1'b0);
      idle(3);
      chk("abort_err_once", err_cnt - e0, 1);
      chk("abort_drained", q_neg.size(), 0);

      // Stray bit in IDLE.
      e0 = err_cnt; m0 = mv_cnt;
      send_bit(1'b1, 1'b0);
      idle(3);
      chk("drop_err_once", err_cnt - e0, 1);
      chk("drop_no_word", mv_cnt - m0, 0);
      send_frame(4'b0110, 4'b1010, 1'b0);
      idle(3);

      // Reset with a pending word and a partial frame.
      m_ready = 1'b0;
      for (int i = 0; i < W; i++) send_bit(1'b1, i == 0);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b0);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      chk("midrst_m_valid", int'(m_valid), 0);
      chk("midrst_m_data", int'(m_data), 0);
      chk("midrst_s_ready", int'(s_ready), 1);
      m_ready = 1'b1;
      send_frame(4'b0110, 4'b1010, 1'b0);
      idle(4);
      chk("final_neg_drained", q_neg.size(), 0);
      chk("final_raw_drained", q_raw.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
